stage_2_id_bypass: RTL
======================

STAGE_2_ID_BYPASS -- requirements
Module: stage_2_id_bypass

Interface
REQ-001 Parameter NUM_BYP, 3, number of downstream writeback sources checked for hazards (EX, MEM, WB order; index 0 youngest).
REQ-002 Parameter PC_RESET_PAYLOAD, 64'h0, payload register value after reset.
REQ-003 Port clk  in  1  sole clock; all state on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports valid_1 in 1 (IF payload valid); allow_2 out 1 (ID can accept); valid_2 out 1 (ID payload valid to EX); allow_3 in 1 (EX can accept).
REQ-006 Port stage_1_to_2  in  64  {inst[31:0], pc[31:0]}.
REQ-007 Ports br_taken out 1, br_target out 32: redirect to IF.
REQ-008 Port stage_2_to_3  out  117  {rf_we, dest[4:0], res_from_mem, alu_src1, alu_src2, alu_op[11:0], mem_we, mem_en, pc}; memory_write_data out 32 (rk/rd value).
REQ-009 Ports rf_raddr1/rf_raddr2 out 5, rf_rdata1/rf_rdata2 in 32: register-file read.
REQ-010 Ports byp_we in NUM_BYP, byp_dest in 5*NUM_BYP, byp_ready in NUM_BYP (data available now), byp_data in 32*NUM_BYP; entry k occupies slice k.

Function
REQ-011 Decode same 20-instruction LA32 subset, alu_op encoding, immediates and bus field order as current ID stage.
REQ-012 Payload register loads stage_1_to_2 and sets valid_r only when valid_1 & allow_2; otherwise holds.
REQ-013 allow_2 = ~valid_r | (ready_go & allow_3); valid_2 = valid_r & ready_go; valid_r clears when valid_2 & allow_3 and no new load.
REQ-014 Source used: rj for all except lu12i/b/bl; rd/rk per src_reg_is_rd; r0 never matches.
REQ-015 Match: entry k hits source s when byp_we[k] & byp_dest[k]==s & s!=0; lowest k hit wins.
REQ-016 Winning hit with byp_ready=1 -> operand = byp_data[k]; with byp_ready=0 -> stall (ready_go=0); no hit -> rf_rdata.
REQ-017 Branch compare, jirl target, alu_src1/src2, memory_write_data all use forwarded values.
REQ-018 br_taken asserted only when valid_r & ready_go & allow_3 & branch-condition true; single cycle per branch.
REQ-019 Instruction accepted from IF in the br_taken cycle is loaded with valid_r=0 (wrong-path kill); next accept is valid normally.
REQ-020 Stall: payload, allow_2=0, valid_2=0, br_taken=0; branch resolves only after stall clears.
REQ-021 allow_3=0 with ready_go=1: hold payload, valid_2=1, br_taken=0.
REQ-022 Latency: IF accept -> valid_2 next cycle absent hazards; back-to-back throughput 1/cycle.

Reset
REQ-023 reset: valid_r=0, payload=PC_RESET_PAYLOAD; thus valid_2=0, br_taken=0, allow_2=1 in first post-reset cycle.
REQ-024 reset mid-stall or mid-branch discards instruction; no br_taken emitted.

Configuration
REQ-025 Macro ID_FORWARD_EN defined: REQ-016 forwarding active.
REQ-026 ID_FORWARD_EN undefined: any hit stalls regardless of byp_ready; byp_data ignored; operands always rf_rdata.

Structure
REQ-027 Shared package: alu_op bit indices, bus widths (117, 64), stage_2_to_3 field offsets, opcode constants.
REQ-028 Sub-module id_hazard_unit: per-source priority match, forward mux, stall output; instantiated twice.
REQ-029 Existing decoder_6_64/4_16/2_4/5_32 reused.

Verification
REQ-030 add.w r3,r1,r2 with byp entry0 {we=1,dest=1,ready=1,data=5}, rf r2=7 -> alu_src1=5, alu_src2=7, valid_2=1.
REQ-031 ld.w writer in entry0 {dest=4,ready=0}, next inst reads r4 -> valid_2=0, allow_2=0 until ready=1, then forwarded value.
REQ-032 beq r1,r1 offs 8 at pc 0x1c000000 -> br_taken one cycle, br_target=0x1c000020; following IF inst killed (valid_2 stays 0 next cycle).
REQ-033 Entries 0 and 2 both dest=5 data 0xA/0xB -> entry0 value 0xA chosen; dest=0 hit ignored.
REQ-034 allow_3=0 for 3 cycles with valid payload -> bus stable, valid_2=1, br_taken=0; reset asserted in 2nd cycle -> valid_2=0 next cycle.
REQ-035 ID_FORWARD_EN undefined, ready hit -> stall one cycle per match until byp_we drops.

Source files
------------

// File: rtl/stage_2_id_bypass_pkg.sv
// Shared definitions for the ID stage with operand bypass: bus widths, field
// offsets, alu_op bit positions and primary opcodes of the LA32 subset.
package stage_2_id_bypass_pkg;

   localparam int IF_BUS_W = 64;
   localparam int ID_BUS_W = 117;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   localparam int BUS_PC_LSB     = 0;
   localparam int BUS_MEM_EN     = 32;
   localparam int BUS_MEM_WE     = 33;
   localparam int BUS_ALU_OP_LSB = 34;
   localparam int BUS_SRC2_LSB   = 46;
   localparam int BUS_SRC1_LSB   = 78;
   localparam int BUS_RES_MEM    = 110;
   localparam int BUS_DEST_LSB   = 111;
   localparam int BUS_RF_WE      = 116;

   localparam logic [5:0] OP_LU12I = 6'h05;
   localparam logic [5:0] OP_MEM   = 6'h0a;
   localparam logic [5:0] OP_JIRL  = 6'h13;
   localparam logic [5:0] OP_B     = 6'h14;
   localparam logic [5:0] OP_BL    = 6'h15;
   localparam logic [5:0] OP_BEQ   = 6'h16;
   localparam logic [5:0] OP_BNE   = 6'h17;

   // Field order matches the EX stage's unpacking, msb first.
   typedef struct packed {
      logic        rf_we;
      logic [4:0]  dest;
      logic        res_from_mem;
      logic [31:0] alu_src1;
      logic [31:0] alu_src2;
      logic [11:0] alu_op;
      logic        mem_we;
      logic        mem_en;
      logic [31:0] pc;
   } id_bus_t;

endpackage

// File: rtl/stage_2_id_bypass_dec.sv
// One-hot opcode field decoders shared by the ID stage.
module decoder_6_64 (
   input  logic [5:0]  in,
   output logic [63:0] out
);
   always_comb for (int i = 0; i < 64; i++) out[i] = (in == 6'(i));
endmodule

module decoder_4_16 (
   input  logic [3:0]  in,
   output logic [15:0] out
);
   always_comb for (int i = 0; i < 16; i++) out[i] = (in == 4'(i));
endmodule

module decoder_2_4 (
   input  logic [1:0] in,
   output logic [3:0] out
);
   always_comb for (int i = 0; i < 4; i++) out[i] = (in == 2'(i));
endmodule

module decoder_5_32 (
   input  logic [4:0]  in,
   output logic [31:0] out
);
   always_comb for (int i = 0; i < 32; i++) out[i] = (in == 5'(i));
endmodule

// File: rtl/stage_2_id_bypass_hazard.sv
// Per-source hazard check against downstream writers; lowest index is youngest.
// ID_FORWARD_EN selects forwarding of ready results instead of stalling on every hit.
module id_hazard_unit #(
   parameter int NUM_BYP = 3
) (
   input  logic [4:0]           src,
   input  logic                 src_used,
   input  logic [NUM_BYP-1:0]   byp_we,
   input  logic [5*NUM_BYP-1:0] byp_dest,
   input  logic [NUM_BYP-1:0]   byp_ready,
   input  logic [32*NUM_BYP-1:0] byp_data,
   input  logic [31:0]          rf_rdata,
   output logic [31:0]          value,
   output logic                 stall
);
   logic        hit_found;
   logic        hit_ready;
   logic [31:0] hit_data;

   // r0 is hardwired zero, so a writer targeting it never creates a hazard.
   always_comb begin
      hit_found = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      for (int k = 0; k < NUM_BYP; k++) begin
         if (!hit_found && src_used && (src != 5'd0) && byp_we[k] &&
             (byp_dest[5*k +: 5] == src)) begin
            hit_found = 1'b1;
            hit_ready = byp_ready[k];
            hit_data  = byp_data[32*k +: 32];
         end
      end
   end

`ifdef ID_FORWARD_EN
   assign stall = hit_found & ~hit_ready;
   assign value = (hit_found & hit_ready) ? hit_data : rf_rdata;
`else
   logic unused_byp;
   assign stall      = hit_found;
   assign value      = rf_rdata;
   assign unused_byp = ^{hit_ready, hit_data};
`endif

endmodule

// File: rtl/stage_2_id_bypass.sv
// ID stage: decodes the LA32 subset, resolves branches and checks operand hazards.
// Define ID_FORWARD_EN to forward ready downstream results instead of stalling.
module stage_2_id_bypass
   import stage_2_id_bypass_pkg::*;
#(
   parameter int          NUM_BYP          = 3,
   parameter logic [63:0] PC_RESET_PAYLOAD = 64'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_1,
   output logic                  allow_2,
   output logic                  valid_2,
   input  logic                  allow_3,
   input  logic [IF_BUS_W-1:0]   stage_1_to_2,
   output logic                  br_taken,
   output logic [31:0]           br_target,
   output logic [ID_BUS_W-1:0]   stage_2_to_3,
   output logic [31:0]           memory_write_data,
   output logic [4:0]            rf_raddr1,
   output logic [4:0]            rf_raddr2,
   input  logic [31:0]           rf_rdata1,
   input  logic [31:0]           rf_rdata2,
   input  logic [NUM_BYP-1:0]    byp_we,
   input  logic [5*NUM_BYP-1:0]  byp_dest,
   input  logic [NUM_BYP-1:0]    byp_ready,
   input  logic [32*NUM_BYP-1:0] byp_data
);
   logic [63:0] payload_q, payload_d;
   logic        valid_q, valid_d;
   logic [31:0] inst, pc;
   logic [63:0] op_31_26_d;
   logic [15:0] op_25_22_d;
   logic [3:0]  op_21_20_d;
   logic [31:0] op_19_15_d;
   logic        unused_dec;

   assign {inst, pc} = payload_q;

   decoder_6_64 u_dec_31_26 (.in(inst[31:26]), .out(op_31_26_d));
   decoder_4_16 u_dec_25_22 (.in(inst[25:22]), .out(op_25_22_d));
   decoder_2_4  u_dec_21_20 (.in(inst[21:20]), .out(op_21_20_d));
   decoder_5_32 u_dec_19_15 (.in(inst[19:15]), .out(op_19_15_d));
   assign unused_dec = ^{op_31_26_d, op_25_22_d, op_21_20_d, op_19_15_d};

   logic rr_grp, sh_grp;
   logic inst_add_w, inst_sub_w, inst_slt, inst_sltu, inst_nor, inst_and, inst_or, inst_xor;
   logic inst_slli_w, inst_srli_w, inst_srai_w, inst_addi_w, inst_ld_w, inst_st_w;
   logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne, inst_lu12i_w;

   assign rr_grp       = op_31_26_d[0] & op_25_22_d[0] & op_21_20_d[1];
   assign sh_grp       = op_31_26_d[0] & op_25_22_d[1] & op_21_20_d[0];
   assign inst_add_w   = rr_grp & op_19_15_d[5'h00];
   assign inst_sub_w   = rr_grp & op_19_15_d[5'h02];
   assign inst_slt     = rr_grp & op_19_15_d[5'h04];
   assign inst_sltu    = rr_grp & op_19_15_d[5'h05];
   assign inst_nor     = rr_grp & op_19_15_d[5'h08];
   assign inst_and     = rr_grp & op_19_15_d[5'h09];
   assign inst_or      = rr_grp & op_19_15_d[5'h0a];
   assign inst_xor     = rr_grp & op_19_15_d[5'h0b];
   assign inst_slli_w  = sh_grp & op_19_15_d[5'h01];
   assign inst_srli_w  = sh_grp & op_19_15_d[5'h09];
   assign inst_srai_w  = sh_grp & op_19_15_d[5'h11];
   assign inst_addi_w  = op_31_26_d[0] & op_25_22_d[4'ha];
   assign inst_ld_w    = op_31_26_d[OP_MEM] & op_25_22_d[4'h2];
   assign inst_st_w    = op_31_26_d[OP_MEM] & op_25_22_d[4'h6];
   assign inst_jirl    = op_31_26_d[OP_JIRL];
   assign inst_b       = op_31_26_d[OP_B];
   assign inst_bl      = op_31_26_d[OP_BL];
   assign inst_beq     = op_31_26_d[OP_BEQ];
   assign inst_bne     = op_31_26_d[OP_BNE];
   assign inst_lu12i_w = op_31_26_d[OP_LU12I] & ~inst[25];

   logic [11:0] alu_op;
   logic        src_reg_is_rd, src1_is_pc, src2_is_imm, src2_is_4, gr_we, use_rj, use_rkd;
   logic [31:0] imm, br_offs, jirl_offs;

   assign alu_op[ALU_ADD]  = inst_add_w | inst_addi_w | inst_ld_w | inst_st_w | inst_jirl | inst_bl;
   assign alu_op[ALU_SUB]  = inst_sub_w;
   assign alu_op[ALU_SLT]  = inst_slt;
   assign alu_op[ALU_SLTU] = inst_sltu;
   assign alu_op[ALU_AND]  = inst_and;
   assign alu_op[ALU_NOR]  = inst_nor;
   assign alu_op[ALU_OR]   = inst_or;
   assign alu_op[ALU_XOR]  = inst_xor;
   assign alu_op[ALU_SLL]  = inst_slli_w;
   assign alu_op[ALU_SRL]  = inst_srli_w;
   assign alu_op[ALU_SRA]  = inst_srai_w;
   assign alu_op[ALU_LUI]  = inst_lu12i_w;

   assign src_reg_is_rd = inst_beq | inst_bne | inst_st_w;
   assign src1_is_pc    = inst_jirl | inst_bl;
   assign src2_is_4     = inst_jirl | inst_bl;
   assign src2_is_imm   = inst_slli_w | inst_srli_w | inst_srai_w | inst_addi_w | inst_ld_w |
                          inst_st_w | inst_lu12i_w | inst_jirl | inst_bl;
   assign gr_we         = ~inst_st_w & ~inst_beq & ~inst_bne & ~inst_b;
   assign use_rj        = ~(inst_lu12i_w | inst_b | inst_bl);
   assign use_rkd       = inst_add_w | inst_sub_w | inst_slt | inst_sltu | inst_nor | inst_and |
                          inst_or | inst_xor | inst_beq | inst_bne | inst_st_w;

   assign imm       = src2_is_4 ? 32'h4 :
                      inst_lu12i_w ? {inst[24:5], 12'b0} : {{20{inst[21]}}, inst[21:10]};
   assign jirl_offs = {{14{inst[25]}}, inst[25:10], 2'b0};
   assign br_offs   = (inst_b | inst_bl) ? {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b0} : jirl_offs;

   assign rf_raddr1 = inst[9:5];
   assign rf_raddr2 = src_reg_is_rd ? inst[4:0] : inst[14:10];

   logic [31:0] rj_value, rkd_value;
   logic        stall_rj, stall_rkd, ready_go, br_cond;

   id_hazard_unit #(.NUM_BYP(NUM_BYP)) u_haz_rj (
      .src(rf_raddr1), .src_used(use_rj), .byp_we(byp_we), .byp_dest(byp_dest),
      .byp_ready(byp_ready), .byp_data(byp_data), .rf_rdata(rf_rdata1),
      .value(rj_value), .stall(stall_rj)
   );

   id_hazard_unit #(.NUM_BYP(NUM_BYP)) u_haz_rkd (
      .src(rf_raddr2), .src_used(use_rkd), .byp_we(byp_we), .byp_dest(byp_dest),
      .byp_ready(byp_ready), .byp_data(byp_data), .rf_rdata(rf_rdata2),
      .value(rkd_value), .stall(stall_rkd)
   );

   assign ready_go  = ~stall_rj & ~stall_rkd;
   assign valid_2   = valid_q & ready_go;
   assign allow_2   = ~valid_q | (ready_go & allow_3);
   assign br_cond   = (inst_beq & (rj_value == rkd_value)) | (inst_bne & (rj_value != rkd_value)) |
                      inst_jirl | inst_b | inst_bl;
   // Reset gating keeps a branch being flushed from redirecting fetch.
   assign br_taken  = ~reset & valid_q & ready_go & allow_3 & br_cond;
   assign br_target = inst_jirl ? (rj_value + jirl_offs) : (pc + br_offs);
   assign memory_write_data = rkd_value;

   id_bus_t bus;

   always_comb begin
      bus              = '0;
      bus.rf_we        = gr_we;
      bus.dest         = inst_bl ? 5'd1 : inst[4:0];
      bus.res_from_mem = inst_ld_w;
      bus.alu_src1     = src1_is_pc ? pc : rj_value;
      bus.alu_src2     = src2_is_imm ? imm : rkd_value;
      bus.alu_op       = alu_op;
      bus.mem_we       = inst_st_w;
      bus.mem_en       = inst_ld_w | inst_st_w;
      bus.pc           = pc;
   end

   assign stage_2_to_3 = bus;

   // A fetch accepted while a branch redirects is on the wrong path and enters invalid.
   always_comb begin
      payload_d = payload_q;
      valid_d   = valid_q;
      if (valid_1 && allow_2) begin
         payload_d = stage_1_to_2;
         valid_d   = ~br_taken;
      end else if (valid_2 && allow_3) begin
         valid_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         payload_q <= PC_RESET_PAYLOAD;
         valid_q   <= 1'b0;
      end else begin
         payload_q <= payload_d;
         valid_q   <= valid_d;
      end
   end

endmodule
